// File: rtl/i2s_master.sv
// rtl/i2s_master.sv - I2S bus master: SCLK/LRCLK generation, stereo TX serializer, RX deserializer
module i2s_master #(
  parameter int DW      = 24,
  parameter int SLOT    = 32,
  parameter int CLK_DIV = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          sclk,
  output logic          lrclk,
  output logic          sdout,
  input  logic          sdin,
  input  logic [DW-1:0] tx_ldata,
  input  logic [DW-1:0] tx_rdata,
  output logic          tx_rd_en,
  input  logic          tx_rd_valid,
  output logic          tx_underflow,
  output logic [DW-1:0] rx_ldata,
  output logic [DW-1:0] rx_rdata,
  output logic          rx_valid
);

  localparam int FW  = 2 * SLOT;
  localparam int DCW = $clog2(CLK_DIV);
  localparam int BCW = $clog2(FW);

  localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(FW - 1);
  localparam logic [BCW-1:0] BC_SLOT  = BCW'(SLOT);
  localparam logic [BCW-1:0] BC_REQ   = BCW'(SLOT - 1);
  localparam logic [BCW-1:0] L_FIRST  = BCW'(1);
  localparam logic [BCW-1:0] L_LAST   = BCW'(DW);
  localparam logic [BCW-1:0] R_FIRST  = BCW'(SLOT + 1);
  localparam logic [BCW-1:0] R_LAST   = BCW'(SLOT + DW);

  // ---------------------------------------------------------------------------
  // Clock generation and bit position
  // ---------------------------------------------------------------------------
  logic [DCW-1:0] div_cnt_q, div_cnt_d;
  logic           sclk_q, sclk_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           lrclk_q, lrclk_d;

  logic           div_wrap;
  logic           rise;
  logic           fall;
  logic           frame_end;
  logic           req_fall;
  logic [BCW-1:0] bit_cnt_nxt;

  assign div_wrap    = (div_cnt_q == DIV_LAST);
  assign rise        = div_wrap & ~sclk_q;
  assign fall        = div_wrap & sclk_q;
  assign frame_end   = fall & (bit_cnt_q == BC_LAST);
  assign req_fall    = fall & (bit_cnt_q == BC_REQ);
  assign bit_cnt_nxt = (bit_cnt_q == BC_LAST) ? '0 : bit_cnt_q + BCW'(1);

  // Divider, SCLK toggle, bit counter advance on falls, LRCLK aligned with falls
  always_comb begin
    div_cnt_d = div_wrap ? '0 : div_cnt_q + DCW'(1);
    sclk_d    = div_wrap ? ~sclk_q : sclk_q;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    if (fall) begin
      bit_cnt_d = bit_cnt_nxt;
      lrclk_d   = (bit_cnt_nxt >= BC_SLOT);
    end
  end

  // Clock-generation state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      lrclk_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
    end
  end

  // ---------------------------------------------------------------------------
  // TX: request/shadow handshake and frame shift register
  // ---------------------------------------------------------------------------
  logic [FW-1:0] tx_sr_q, tx_sr_d;
  logic          sdout_q, sdout_d;
  logic [DW-1:0] shadow_l_q, shadow_l_d;
  logic [DW-1:0] shadow_r_q, shadow_r_d;
  logic          shadow_full_q, shadow_full_d;
  logic          pending_q, pending_d;
  logic          tx_rd_en_q, tx_rd_en_d;
  logic          tx_underflow_q, tx_underflow_d;
  logic [FW-1:0] load_word;

  // Frame image indexed so that bit FW-1 is bit_cnt 0; slot bit 0 and the tail
  // of each slot past DW stay zero.
  assign load_word = ({{(FW-DW){1'b0}}, shadow_l_q} << (FW - 1 - DW))
                   | ({{(FW-DW){1'b0}}, shadow_r_q} << (SLOT - 1 - DW));

  // Frame load/shift on falls, shadow capture while a request is pending
  always_comb begin
    tx_sr_d        = tx_sr_q;
    sdout_d        = sdout_q;
    shadow_l_d     = shadow_l_q;
    shadow_r_d     = shadow_r_q;
    shadow_full_d  = shadow_full_q;
    pending_d      = pending_q;
    tx_rd_en_d     = 1'b0;
    tx_underflow_d = 1'b0;

    if (frame_end) begin
      if (shadow_full_q) begin
        sdout_d = load_word[FW-1];
        tx_sr_d = load_word << 1;
      end else begin
        sdout_d        = 1'b0;
        tx_sr_d        = '0;
        tx_underflow_d = 1'b1;
      end
      shadow_full_d = 1'b0;
    end else if (fall) begin
      sdout_d = tx_sr_q[FW-1];
      tx_sr_d = tx_sr_q << 1;
    end

    // A capture landing on the load edge is kept for the following frame.
    if (pending_q && tx_rd_valid) begin
      shadow_l_d    = tx_ldata;
      shadow_r_d    = tx_rdata;
      shadow_full_d = 1'b1;
      pending_d     = 1'b0;
    end

    // An unanswered request is not re-issued; it stays open across frames.
    if (req_fall && !pending_d) begin
      tx_rd_en_d = 1'b1;
      pending_d  = 1'b1;
    end
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sr_q        <= '0;
      sdout_q        <= 1'b0;
      shadow_l_q     <= '0;
      shadow_r_q     <= '0;
      shadow_full_q  <= 1'b0;
      pending_q      <= 1'b0;
      tx_rd_en_q     <= 1'b0;
      tx_underflow_q <= 1'b0;
    end else begin
      tx_sr_q        <= tx_sr_d;
      sdout_q        <= sdout_d;
      shadow_l_q     <= shadow_l_d;
      shadow_r_q     <= shadow_r_d;
      shadow_full_q  <= shadow_full_d;
      pending_q      <= pending_d;
      tx_rd_en_q     <= tx_rd_en_d;
      tx_underflow_q <= tx_underflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RX: per-channel shift registers fed on rises, published at frame end
  // ---------------------------------------------------------------------------
  logic [DW-1:0] rx_l_sr_q, rx_l_sr_d;
  logic [DW-1:0] rx_r_sr_q, rx_r_sr_d;
  logic [DW-1:0] rx_ldata_q, rx_ldata_d;
  logic [DW-1:0] rx_rdata_q, rx_rdata_d;
  logic          rx_valid_q, rx_valid_d;
  logic          in_left;
  logic          in_right;

  assign in_left  = (bit_cnt_q >= L_FIRST) && (bit_cnt_q <= L_LAST);
  assign in_right = (bit_cnt_q >= R_FIRST) && (bit_cnt_q <= R_LAST);

  // Shift in data bits of each slot; the last rise of the frame publishes both
  always_comb begin
    rx_l_sr_d  = rx_l_sr_q;
    rx_r_sr_d  = rx_r_sr_q;
    rx_ldata_d = rx_ldata_q;
    rx_rdata_d = rx_rdata_q;
    rx_valid_d = 1'b0;
    if (rise && in_left) begin
      rx_l_sr_d = {rx_l_sr_q[DW-2:0], sdin};
    end
    if (rise && in_right) begin
      rx_r_sr_d = {rx_r_sr_q[DW-2:0], sdin};
    end
    // Use the next-state values: with SLOT == DW+1 the last right bit
    // arrives on this very rise.
    if (rise && (bit_cnt_q == BC_LAST)) begin
      rx_ldata_d = rx_l_sr_d;
      rx_rdata_d = rx_r_sr_d;
      rx_valid_d = 1'b1;
    end
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_l_sr_q  <= '0;
      rx_r_sr_q  <= '0;
      rx_ldata_q <= '0;
      rx_rdata_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_l_sr_q  <= rx_l_sr_d;
      rx_r_sr_q  <= rx_r_sr_d;
      rx_ldata_q <= rx_ldata_d;
      rx_rdata_q <= rx_rdata_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign sclk         = sclk_q;
  assign lrclk        = lrclk_q;
  assign sdout        = sdout_q;
  assign tx_rd_en     = tx_rd_en_q;
  assign tx_underflow = tx_underflow_q;
  assign rx_ldata     = rx_ldata_q;
  assign rx_rdata     = rx_rdata_q;
  assign rx_valid     = rx_valid_q;

endmodule
